dds_core: RTL and testbench

DDS_CORE -- requirements
Module: dds_core

---
 rtl/dds_pkg.sv | 41 ++++
 rtl/dds_core_sine_rom.sv | 35 +++
 rtl/dds_core.sv | 141 ++++++++++++++
 tb/tb_dds_core.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared constants, waveform codes and the control-parameter bundle for the DDS core.
// Also holds the amplitude-scaling helper used when AMP_SCALE_EN is defined.
package dds_pkg;

   localparam int ACC_W  = 32;
   localparam int ADDR_W = 9;
   localparam int DATA_W = 8;
   localparam int F_W    = 21;
   localparam int A_W    = 4;

   typedef enum logic [1:0] {
      WAVE_SINE   = 2'b00,
      WAVE_SQUARE = 2'b01,
      WAVE_TRI    = 2'b10,
      WAVE_SAW    = 2'b11
   } wave_t;

   localparam logic [F_W-1:0] F_RESET = 21'd8590;
   localparam logic [A_W-1:0] A_RESET = 4'd1;
   localparam logic [A_W-1:0] A_MAX   = 4'd10;

   typedef struct packed {
      logic [F_W-1:0]    f;
      wave_t             wave;
      logic [A_W-1:0]    a;
      logic [ADDR_W-1:0] p;
   } param_t;

   localparam param_t PARAM_RESET = '{f: F_RESET, wave: WAVE_SINE, a: A_RESET, p: '0};

   // floor(s*a/10) as s*a*6554 >> 16; the error stays below one LSB for products up to 2550.
   function automatic logic [DATA_W-1:0] amp_scale(input logic [DATA_W-1:0] s,
                                                  input logic [A_W-1:0]    a);
      logic [A_W-1:0]        a_sat;
      logic [DATA_W+A_W-1:0] prod;
      a_sat = (a > A_MAX) ? A_MAX : a;
      prod  = s * a_sat;
      return DATA_W'((prod * 25'd6554) >> 16);
   endfunction

endpackage

// File: rtl/dds_core_sine_rom.sv
// 512 x 8 sine table with a registered read port; entries are
// round(127.5 + 127.5*sin(2*pi*addr/512)), fixed at elaboration.
module sine_rom
   import dds_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data
);

   function automatic logic [DATA_W-1:0] sine_entry(input int idx);
      real ph;
      ph = 2.0 * 3.14159265358979323846 * real'(idx) / real'(2 ** ADDR_W);
      return DATA_W'($rtoi($floor(127.5 + 127.5 * $sin(ph) + 0.5)));
   endfunction

   logic [DATA_W-1:0] rom [2 ** ADDR_W];

   for (genvar i = 0; i < 2 ** ADDR_W; i++) begin : g_rom
      assign rom[i] = sine_entry(i);
   end

   logic [DATA_W-1:0] data_q, data_d;

   always_comb data_d = rom[addr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) data_q <= '0;
      else     data_q <= data_d;
   end

   assign data = data_q;

endmodule

// File: rtl/dds_core.sv
// DDS core: synchronized control inputs, parameter update aligned to accumulator wrap,
// and a 3-stage sample pipeline. Define AMP_SCALE_EN to enable amplitude scaling in stage 3.
module dds_core
   import dds_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        set_waveform,
   input  logic [F_W-1:0]    f_control,
   input  logic [A_W-1:0]    a_control,
   input  logic [ADDR_W-1:0] p_control,
   output logic [DATA_W-1:0] dac_data,
   output logic              dac_valid
);

   param_t raw;
   param_t sync1_q, sync1_d, sync2_q, sync2_d, cand_q, cand_d, act_q, act_d;
   logic [ACC_W-1:0] phase_acc_q, phase_acc_d;
   logic             carry;

   logic [ADDR_W-1:0] addr_p1_q, addr_p1_d;
   wave_t             wave_p1_q, wave_p1_d;
   logic              vld_p1_q, vld_p1_d;

   logic [DATA_W-1:0] rom_p2;
   logic [DATA_W-1:0] shape_p2_q, shape_p2_d;
   wave_t             wave_p2_q, wave_p2_d;
   logic              vld_p2_q, vld_p2_d;

   logic [DATA_W-1:0] sample_p2;
   logic [DATA_W-1:0] dac_q, dac_d;
   logic              dac_valid_q, dac_valid_d;

   assign raw = '{f: f_control, wave: wave_t'(set_waveform), a: a_control, p: p_control};

   // Control: two-flop sync, candidate accepted when the synced value holds for two cycles
   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
      cand_d  = cand_q;
      if (sync1_q.f    == sync2_q.f)    cand_d.f    = sync2_q.f;
      if (sync1_q.wave == sync2_q.wave) cand_d.wave = sync2_q.wave;
      if (sync1_q.a    == sync2_q.a)    cand_d.a    = sync2_q.a;
      if (sync1_q.p    == sync2_q.p)    cand_d.p    = sync2_q.p;
      {carry, phase_acc_d} = {1'b0, phase_acc_q} + {{(ACC_W - F_W + 1){1'b0}}, act_q.f};
      act_d = (carry || act_q.f == '0) ? cand_q : act_q;
   end

   // Stage 1: table address
   always_comb begin
      addr_p1_d = phase_acc_q[ACC_W-1 -: ADDR_W] + act_q.p;
      wave_p1_d = act_q.wave;
      vld_p1_d  = 1'b1;
   end

   // Stage 2: raw sample (sine comes from the registered ROM)
   always_comb begin
      case (wave_p1_q)
         WAVE_SQUARE: shape_p2_d = addr_p1_q[ADDR_W-1] ? '0 : '1;
         WAVE_TRI:    shape_p2_d = addr_p1_q[ADDR_W-1] ? ~addr_p1_q[DATA_W-1:0]
                                                       : addr_p1_q[DATA_W-1:0];
         default:     shape_p2_d = addr_p1_q[ADDR_W-1:1];
      endcase
      wave_p2_d = wave_p1_q;
      vld_p2_d  = vld_p1_q;
   end

   sine_rom u_sine_rom (
      .clk  (clk),
      .rst  (reset),
      .addr (addr_p1_q),
      .data (rom_p2)
   );

   assign sample_p2 = (wave_p2_q == WAVE_SINE) ? rom_p2 : shape_p2_q;

`ifdef AMP_SCALE_EN
   logic [A_W-1:0] a_p1_q, a_p2_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_p1_q <= A_RESET;
         a_p2_q <= A_RESET;
      end else begin
         a_p1_q <= act_q.a;
         a_p2_q <= a_p1_q;
      end
   end

   // Stage 3: scaled output, held at zero until the pipeline is full
   always_comb begin
      dac_d       = vld_p2_q ? amp_scale(sample_p2, a_p2_q) : '0;
      dac_valid_d = vld_p2_q;
   end
`else
   logic unused_amp;
   assign unused_amp = ^act_q.a;

   // Stage 3: plain output register, held at zero until the pipeline is full
   always_comb begin
      dac_d       = vld_p2_q ? sample_p2 : '0;
      dac_valid_d = vld_p2_q;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q     <= PARAM_RESET;
         sync2_q     <= PARAM_RESET;
         cand_q      <= PARAM_RESET;
         act_q       <= PARAM_RESET;
         phase_acc_q <= '0;
         addr_p1_q   <= '0;
         wave_p1_q   <= WAVE_SINE;
         vld_p1_q    <= 1'b0;
         shape_p2_q  <= '0;
         wave_p2_q   <= WAVE_SINE;
         vld_p2_q    <= 1'b0;
         dac_q       <= '0;
         dac_valid_q <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         cand_q      <= cand_d;
         act_q       <= act_d;
         phase_acc_q <= phase_acc_d;
         addr_p1_q   <= addr_p1_d;
         wave_p1_q   <= wave_p1_d;
         vld_p1_q    <= vld_p1_d;
         shape_p2_q  <= shape_p2_d;
         wave_p2_q   <= wave_p2_d;
         vld_p2_q    <= vld_p2_d;
         dac_q       <= dac_d;
         dac_valid_q <= dac_valid_d;
      end
   end

   assign dac_data  = dac_q;
   assign dac_valid = dac_valid_q;

endmodule

// File: tb/tb_dds_core.sv
// Scoreboard bench for dds_core: a behavioural model queues the expected sample for
// every clock edge and an independent monitor pops and compares while dac_valid is high.
module tb_dds_core;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  set_waveform;
   logic [20:0] f_control;
   logic [3:0]  a_control;
   logic [8:0]  p_control;
   logic [7:0]  dac_data;
   logic        dac_valid;

   int checks = 0;
   int errors = 0;

   dds_core dut (
      .clk          (clk),
      .reset        (reset),
      .set_waveform (set_waveform),
      .f_control    (f_control),
      .a_control    (a_control),
      .p_control    (p_control),
      .dac_data     (dac_data),
      .dac_valid    (dac_valid)
   );

   always #10 clk = ~clk;

   typedef struct {
      int f;
      int w;
      int a;
      int p;
   } prm_t;

   prm_t            hist [2];
   prm_t            cand_m;
   prm_t            act_m;
   longint unsigned acc_m = 0;
   int              edges_m = 0;
   int              exp_q[$];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic prm_t reset_prm();
      prm_t r;
      r.f = 8590;
      r.w = 0;
      r.a = 1;
      r.p = 0;
      return r;
   endfunction

   function automatic int ref_sample(input longint unsigned acc, input prm_t prm);
      int addr;
      int s;
`ifdef AMP_SCALE_EN
      int a;
`endif
      addr = (int'(acc >> 23) + prm.p) % 512;
      case (prm.w)
         0:       s = int'($floor(127.5 + 127.5 * $sin(2.0 * 3.14159265358979323846 * addr / 512.0) + 0.5));
         1:       s = (addr < 256) ? 255 : 0;
         2:       s = (addr < 256) ? addr : 511 - addr;
         default: s = addr / 2;
      endcase
`ifdef AMP_SCALE_EN
      a = (prm.a > 10) ? 10 : prm.a;
      s = (s * a) / 10;
`endif
      return s;
   endfunction

   task automatic model_reset();
      acc_m   = 0;
      edges_m = 0;
      cand_m  = reset_prm();
      act_m   = reset_prm();
      hist[0] = reset_prm();
      hist[1] = reset_prm();
      exp_q.delete();
   endtask

   task automatic model_step();
      prm_t            cur;
      prm_t            nc;
      longint unsigned sum;
      cur.f = int'(f_control);
      cur.w = int'(set_waveform);
      cur.a = int'(a_control);
      cur.p = int'(p_control);
      exp_q.push_back(ref_sample(acc_m, act_m));
      sum = acc_m + longint'(act_m.f);
      // a synchronized value becomes a candidate once seen on two consecutive cycles
      nc = cand_m;
      if (hist[0].f == hist[1].f) nc.f = hist[1].f;
      if (hist[0].w == hist[1].w) nc.w = hist[1].w;
      if (hist[0].a == hist[1].a) nc.a = hist[1].a;
      if (hist[0].p == hist[1].p) nc.p = hist[1].p;
      if (sum >= 64'h1_0000_0000 || act_m.f == 0) act_m = cand_m;
      acc_m   = sum & 64'hFFFF_FFFF;
      cand_m  = nc;
      hist[1] = hist[0];
      hist[0] = cur;
      if (edges_m < 3) edges_m++;
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) model_reset();
      else       model_step();
   end

   // Monitor
   initial begin
      forever begin
         @(posedge clk);
         #1;
         check("phase_acc", longint'(dut.phase_acc_q), longint'(acc_m));
         if (reset) begin
            check("reset_data", dac_data, 0);
            check("reset_valid", dac_valid, 0);
         end else begin
            check("dac_valid", dac_valid, (edges_m >= 3) ? 1 : 0);
            if (edges_m < 3) check("fill_data", dac_data, 0);
            if (dac_valid) begin
               check("exp_queue_nonempty", (exp_q.size() > 0) ? 1 : 0, 1);
               if (exp_q.size() > 0) check("dac_data", dac_data, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #(100000 * 20);
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog expired");
   end

   task automatic set_in(input int f, input int w, input int a, input int p);
      @(negedge clk);
      f_control    = 21'(f);
      set_waveform = 2'(w);
      a_control    = 4'(a);
      p_control    = 9'(p);
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int n;
      longint unsigned acc0;
      f_control    = 21'd8590;
      set_waveform = 2'd0;
      a_control    = 4'd1;
      p_control    = 9'd0;
      reset        = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      run(20);

      // square wave, full amplitude, then half amplitude, then half-cycle phase offset
      set_in(2097151, 1, 10, 0);
      run(4500);
      set_in(2097151, 1, 5, 0);
      run(2500);
      set_in(2097151, 1, 5, 256);
      run(3000);

      // frozen accumulator, then restart without waiting for a wrap
      set_in(0, 2, 7, 0);
      run(2300);
      run(100);
      acc0 = acc_m;
      set_in(8590, 2, 7, 0);
      n = 0;
      while (dut.phase_acc_q == acc0[31:0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("f_resume_within_5", (n <= 5) ? 1 : 0, 1);
      run(20);

      // randomized parameter sets, some with single-cycle input glitches
      for (int i = 0; i < 40; i++) begin
         int f;
         int w;
         int a;
         int p;
         f = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1 << 19, (1 << 21) - 1));
         w = int'($urandom_range(0, 3));
         a = int'($urandom_range(0, 15));
         p = int'($urandom_range(0, 511));
         set_in(f, w, a, p);
         if ($urandom_range(0, 2) == 0) begin
            set_in(int'($urandom_range(0, (1 << 21) - 1)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 511)));
            set_in(f, w, a, p);
         end
         run(int'($urandom_range(200, 500)));
      end

      // sine, then a one-cycle reset pulse mid-stream
      set_in(8590, 0, 10, 0);
      run(600);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("async_reset_data", dac_data, 0);
      check("async_reset_valid", dac_valid, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("restart_valid", dac_valid, 1);
      check("restart_sample", dac_data, ref_sample(0, reset_prm()));
      run(50);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
